// File: rtl/codec_intf.sv
// codec_intf: clock generation, reset release and I2S serial data paths
// between the equalizer datapath and a CS4272 audio CODEC.
// A free-running 10-bit counter sets the timing of the whole block. All CODEC
// clocks are taken straight from counter flops, so they cannot glitch.
module codec_intf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              valid,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  input  logic              SDout,
  output logic              SDin,
  output logic              RSTn
);

  // Last slot that carries sample data. Data occupies slots 1..DATA_W.
  localparam logic [4:0] LAST_SLOT = 5'(DATA_W);
  localparam logic [9:0] CNT_LAST  = 10'h3FF;
  localparam logic [3:0] RISE_PH   = 4'd7;
  localparam logic [3:0] FALL_PH   = 4'd15;

  // Before the first counter wrap the CODEC is held in reset and data is
  // ignored. After the wrap, frames are live until the next rst_n.
  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_LIVE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [9:0]        cnt_r;
  logic [9:0]        cnt_nxt_s;
  logic [4:0]        slot_s;
  logic [4:0]        nxt_slot_s;
  logic              nxt_lr_s;
  logic              rise_s;
  logic              fall_s;
  logic              wrap_s;
  logic              live_s;
  logic              boundary_s;
  logic              rx_en_s;
  logic              tx_bit_s;

  logic [DATA_W-1:0] lft_sh_r;
  logic [DATA_W-1:0] rht_sh_r;
  logic [DATA_W-1:0] lft_hold_r;
  logic [DATA_W-1:0] rht_hold_r;
  logic [DATA_W-1:0] lft_in_r;
  logic [DATA_W-1:0] rht_in_r;
  logic              valid_r;
  logic              sdin_r;
  logic              rstn_r;

  // Returns the bit for slot 'slot' of a held sample: MSB in slot 1, LSB in
  // slot DATA_W, and zero in slot 0 and in every slot after the LSB.
  function automatic logic tx_bit(input logic [DATA_W-1:0] hold,
                                  input logic [4:0]        slot);
    logic [DATA_W-1:0] aligned;
    logic              bit_v;
    aligned = hold << (slot - 5'd1);
    if ((slot >= 5'd1) && (slot <= LAST_SLOT)) begin
      bit_v = aligned[DATA_W-1];
    end else begin
      bit_v = 1'b0;
    end
    return bit_v;
  endfunction

  // Decode the timing signals from the counter.
  always_comb begin
    cnt_nxt_s  = cnt_r + 10'd1;
    slot_s     = cnt_r[8:4];
    nxt_slot_s = cnt_nxt_s[8:4];
    nxt_lr_s   = cnt_nxt_s[9];
    rise_s     = (cnt_r[3:0] == RISE_PH);
    fall_s     = (cnt_r[3:0] == FALL_PH);
    wrap_s     = (cnt_r == CNT_LAST);
    live_s     = (state_r == ST_LIVE);
    boundary_s = wrap_s && live_s;
    rx_en_s    = live_s && rise_s && (slot_s >= 5'd1) && (slot_s <= LAST_SLOT);
  end

  // Pick the DAC bit for the slot that begins after this SCLK fall. The
  // channel is the one selected by the next LRCLK value.
  always_comb begin
    tx_bit_s = 1'b0;
    if (live_s) begin
      if (nxt_lr_s) begin
        tx_bit_s = tx_bit(rht_hold_r, nxt_slot_s);
      end else begin
        tx_bit_s = tx_bit(lft_hold_r, nxt_slot_s);
      end
    end else begin
      tx_bit_s = 1'b0;
    end
  end

  // Compute the next live state. The first counter wrap releases the CODEC.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (wrap_s) begin
          state_s = ST_LIVE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_LIVE: state_s = ST_LIVE;
      default: state_s = ST_WAIT;
    endcase
  end

  // Live-state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Free-running frame counter. It wraps 0x3FF -> 0x000.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 10'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // CODEC reset output. It goes high on the cycle after the first wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstn_r <= 1'b0;
    end else begin
      rstn_r <= (state_s == ST_LIVE);
    end
  end

  // Shift ADC bits MSB-first into the current channel's register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_sh_r <= '0;
      rht_sh_r <= '0;
    end else if (rx_en_s) begin
      if (cnt_r[9]) begin
        rht_sh_r <= {rht_sh_r[DATA_W-2:0], SDout};
      end else begin
        lft_sh_r <= {lft_sh_r[DATA_W-2:0], SDout};
      end
    end
  end

  // At the frame boundary, publish the received samples and latch the
  // samples to transmit in the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lft_in_r   <= '0;
      rht_in_r   <= '0;
      lft_hold_r <= '0;
      rht_hold_r <= '0;
    end else if (boundary_s) begin
      lft_in_r   <= lft_sh_r;
      rht_in_r   <= rht_sh_r;
      lft_hold_r <= lft_out;
      rht_hold_r <= rht_out;
    end
  end

  // One-cycle frame strobe. It is high on the cycle where cnt is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= boundary_s;
    end
  end

  // DAC serial data. It changes only on SCLK falls, so it is stable around each rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sdin_r <= 1'b0;
    end else if (fall_s) begin
      sdin_r <= tx_bit_s;
    end
  end

  assign MCLK   = cnt_r[1];
  assign SCLK   = cnt_r[3];
  assign LRCLK  = cnt_r[9];
  assign RSTn   = rstn_r;
  assign valid  = valid_r;
  assign SDin   = sdin_r;
  assign lft_in = lft_in_r;
  assign rht_in = rht_in_r;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf. A frame-level reference model computes
// every output from the time since reset release and the sample words each
// frame carries. A directed table, a randomized phase with a mid-frame reset
// and a CODEC loopback phase drive the stimulus.
module tb_codec_intf;

  localparam int W     = 16;
  localparam int FRAME = 1024;
  localparam int N     = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] lft_out;
  logic [W-1:0] rht_out;
  logic [W-1:0] lft_in;
  logic [W-1:0] rht_in;
  logic         valid;
  logic         MCLK;
  logic         SCLK;
  logic         LRCLK;
  logic         SDout;
  logic         SDin;
  logic         RSTn;

  codec_intf #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lft_out(lft_out),
    .rht_out(rht_out),
    .lft_in (lft_in),
    .rht_in (rht_in),
    .valid  (valid),
    .MCLK   (MCLK),
    .SCLK   (SCLK),
    .LRCLK  (LRCLK),
    .SDout  (SDout),
    .SDin   (SDin),
    .RSTn   (RSTn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] adc_l;
    logic [W-1:0] adc_r;
    logic [W-1:0] dac_l;
    logic [W-1:0] dac_r;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
    logic [31:0]  tx_l;
    logic [31:0]  tx_r;
  } vec_t;

  vec_t         tab [0:N-1];

  int           checks = 0;
  int           errors = 0;
  int           k = 0;            // clock edges since reset release
  int           mode = 0;         // 0 directed, 1 random, 2 loopback
  int           lb_start = 0;
  int           first_valid = -1;
  int           first_rstn = -1;
  logic         junk = 1'b0;

  // Per-frame records: ADC words sent, DAC words presented at the boundary,
  // and the slot vectors the CODEC side sampled from SDin (bit 31-s = slot s).
  logic [W-1:0] adc_l [0:31];
  logic [W-1:0] adc_r [0:31];
  logic [W-1:0] dac_l [0:31];
  logic [W-1:0] dac_r [0:31];
  logic [31:0]  cap_l [0:31];
  logic [31:0]  cap_r [0:31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at k=%0d", name, act, exp, k);
    end
  endtask

  function automatic logic [W-1:0] ramp_l(input int g);
    return W'(g - lb_start);
  endfunction

  function automatic logic [W-1:0] ramp_r(input int g);
    return W'(16'h0100 + g - lb_start);
  endfunction

  // Choose the ADC words for frame f.
  task automatic prepare_frame(input int f);
    cap_l[f] = 32'd0;
    cap_r[f] = 32'd0;
    case (mode)
      0: begin
        if (f == 0) begin
          adc_l[f] = 16'hFFFF;
          adc_r[f] = 16'hFFFF;
        end else if (f <= N) begin
          adc_l[f] = tab[f-1].adc_l;
          adc_r[f] = tab[f-1].adc_r;
        end else begin
          adc_l[f] = 16'h0000;
          adc_r[f] = 16'h0000;
        end
      end
      1: begin
        adc_l[f] = W'($urandom);
        adc_r[f] = W'($urandom);
      end
      default: begin
        // CODEC loopback: replay what the DAC side received last frame.
        if (f > 0) begin
          adc_l[f] = cap_l[f-1][30 -: W];
          adc_r[f] = cap_r[f-1][30 -: W];
        end else begin
          adc_l[f] = 16'h0000;
          adc_r[f] = 16'h0000;
        end
      end
    endcase
  endtask

  // Drive SDout for the current slot, and drive the DAC samples.
  task automatic drive_inputs();
    int f;
    int c;
    int s;
    logic [W-1:0] smp;
    f = k / FRAME;
    c = k % FRAME;
    if (c == 0) prepare_frame(f);
    if (c % 16 == 0) junk = 1'($urandom_range(0, 1));
    s = (c % 512) / 16;
    smp = (c >= 512) ? adc_r[f] : adc_l[f];
    if (s >= 1 && s <= W) SDout = smp[W-s];
    else SDout = junk;
    case (mode)
      0: begin
        if (f >= 1 && f <= N) begin
          lft_out = tab[f-1].dac_l;
          rht_out = tab[f-1].dac_r;
        end else if (f == 0) begin
          lft_out = 16'hFFFF;
          rht_out = 16'hFFFF;
        end else begin
          lft_out = 16'h0000;
          rht_out = 16'h0000;
        end
      end
      1: begin
        lft_out = W'($urandom);
        rht_out = W'($urandom);
      end
      default: begin
        lft_out = ramp_l(f);
        rht_out = ramp_r(f);
      end
    endcase
    if ((k + 1) % FRAME == 0) begin
      dac_l[(k+1)/FRAME] = lft_out;
      dac_r[(k+1)/FRAME] = rht_out;
    end
  endtask

  // Expected SDin: the value driven at the latest SCLK fall (edge e, a
  // multiple of 16), which selects slot e%512/16 of frame e/1024.
  function automatic logic model_sdin(input int kk);
    int e;
    int f;
    int p;
    int s;
    logic [W-1:0] w;
    e = kk - (kk % 16);
    if (e < FRAME + 16) return 1'b0;
    f = e / FRAME;
    p = e % FRAME;
    s = (p % 512) / 16;
    if (f < 2 || s < 1 || s > W) return 1'b0;
    w = (p >= 512) ? dac_r[f] : dac_l[f];
    return w[W-s];
  endfunction

  task automatic check_cycle();
    int c;
    int f;
    logic [W-1:0] e_l;
    logic [W-1:0] e_r;
    logic e_mclk, e_sclk, e_lr, e_rstn, e_valid, e_sdin;
    c = k % FRAME;
    f = k / FRAME;
    e_mclk  = 1'((c / 2) % 2);
    e_sclk  = 1'((c / 8) % 2);
    e_lr    = 1'((c / 512) % 2);
    e_rstn  = (k >= FRAME);
    e_valid = (k >= 2 * FRAME) && (c == 0);
    e_sdin  = model_sdin(k);
    if (f >= 2) begin
      e_l = adc_l[f-1];
      e_r = adc_r[f-1];
    end else begin
      e_l = '0;
      e_r = '0;
    end
    check("cycle{mclk,sclk,lrclk,rstn,valid,sdin,lft_in,rht_in}",
          64'({MCLK, SCLK, LRCLK, RSTn, valid, SDin, lft_in, rht_in}),
          64'({e_mclk, e_sclk, e_lr, e_rstn, e_valid, e_sdin, e_l, e_r}));
  endtask

  // Record the SDin bits that the CODEC side samples on SCLK rises.
  task automatic capture_sdin();
    int c;
    int f;
    int s;
    c = k % FRAME;
    f = k / FRAME;
    if (c % 16 == 8) begin
      s = (c % 512) / 16;
      if (c >= 512) cap_r[f][31-s] = SDin;
      else cap_l[f][31-s] = SDin;
    end
  endtask

  task automatic step();
    logic in_rst;
    in_rst = !rst_n;
    @(posedge clk);
    if (in_rst) k = 0;
    else k = k + 1;
    #1;
    drive_inputs();
    @(negedge clk);
    check_cycle();
    capture_sdin();
    if (valid && first_valid < 0) first_valid = k;
    if (RSTn && first_rstn < 0) first_rstn = k;
  endtask

  task automatic run_to(input int target);
    while (k < target && errors < 50) step();
  endtask

  initial begin
    tab[0] = '{16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234, 32'h4000_8000, 32'h3FFF_0000};
    tab[1] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 32'h7FFF_8000, 32'h0000_0000};
    tab[2] = '{16'h0001, 16'hFFFE, 16'h0001, 16'h8000, 16'h0001, 16'hFFFE, 32'h0000_8000, 32'h4000_0000};
    tab[3] = '{16'h0000, 16'hFFFF, 16'h5A5A, 16'hC33C, 16'h0000, 16'hFFFF, 32'h2D2D_0000, 32'h619E_0000};

    rst_n   = 1'b0;
    lft_out = '0;
    rht_out = '0;
    SDout   = 1'b0;

    // Hold reset for 5 clocks. The model expects every output at zero.
    for (int i = 0; i < 5; i++) step();
    check("reset_outputs", 64'({RSTn, valid, SDin, MCLK, SCLK, LRCLK, lft_in, rht_in}), 64'd0);
    rst_n = 1'b1;
    first_valid = -1;
    first_rstn  = -1;

    // Directed frames from the table.
    for (int g = 1; g <= N + 1; g++) begin
      run_to((g + 1) * FRAME);
      if (g <= N) begin
        check("rx_lft", 64'(lft_in), 64'(tab[g-1].exp_l));
        check("rx_rht", 64'(rht_in), 64'(tab[g-1].exp_r));
      end
      if (g == 1) begin
        check("tx_first_live_lft", 64'(cap_l[1]), 64'd0);
        check("tx_first_live_rht", 64'(cap_r[1]), 64'd0);
      end else begin
        check("tx_slots_lft", 64'(cap_l[g]), 64'(tab[g-2].tx_l));
        check("tx_slots_rht", 64'(cap_r[g]), 64'(tab[g-2].tx_r));
      end
    end
    check("first_rstn", 64'(first_rstn), 64'(FRAME));
    check("first_valid", 64'(first_valid), 64'(2 * FRAME));

    // Random stimulus. Assert reset for one clock at cnt==0x150.
    mode = 1;
    run_to(k + 16'h150);
    rst_n = 1'b0;
    step();
    check("mid_reset_outputs", 64'({RSTn, valid, SDin, MCLK, SCLK, LRCLK, lft_in, rht_in}), 64'd0);
    rst_n = 1'b1;
    first_valid = -1;
    first_rstn  = -1;
    run_to(4 * FRAME - 1);
    check("mid_reset_first_rstn", 64'(first_rstn), 64'(FRAME));
    check("mid_reset_first_valid", 64'(first_valid), 64'(2 * FRAME));

    // Loopback through a CODEC model with ramp samples.
    mode = 2;
    lb_start = 4;
    for (int b = lb_start + 3; b <= lb_start + 8; b++) begin
      run_to(b * FRAME);
      check("loop_lft_in", 64'(lft_in), 64'(ramp_l(b - 3)));
      check("loop_rht_in", 64'(rht_in), 64'(ramp_r(b - 3)));
      check("loop_aout_lft", 64'(cap_l[b-1][30 -: W]), 64'(ramp_l(b - 2)));
      check("loop_aout_rht", 64'(cap_r[b-1][30 -: W]), 64'(ramp_r(b - 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Digital-audio interface between the equalizer datapath and the CS4272 CODEC.
- Generates MCLK, SCLK and LRCLK, and releases the CODEC reset (RSTn).
- Deserializes the I2S ADC stream (SDout) into left/right samples with a frame-valid strobe.
- Serializes processed left/right samples onto the DAC stream (SDin).
- Sits directly upstream (sample source) and downstream (sample sink) of the equalizer filter banks.

Parameters:
DATA_W, 16, sample width in bits; legal range 8..24; unused slot bits are zero.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
lft_out  input  DATA_W  left sample to send to the DAC; captured at frame boundary.
rht_out  input  DATA_W  right sample to send to the DAC; captured at frame boundary.
lft_in  output  DATA_W  left sample received from the ADC.
rht_in  output  DATA_W  right sample received from the ADC.
valid  output  1  one-clk pulse: new lft_in/rht_in present, lft_out/rht_out just consumed.
MCLK  output  1  CODEC master clock, clk/4.
SCLK  output  1  serial bit clock, clk/16.
LRCLK  output  1  frame clock, clk/1024; low = left channel, high = right channel.
SDout  input  1  serial ADC data from CODEC.
SDin  output  1  serial DAC data to CODEC.
RSTn  output  1  CODEC reset, active low.

Behaviour:
- Free-running 10-bit counter cnt increments every clk and wraps 0x3FF -> 0x000.
- All clock outputs are derived directly from cnt bits, with no glitches: MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9].
- Slot index is slot = cnt[8:4] (0..31) within the current channel.
- Strobes:
  - rise = (cnt[3:0]==7): SCLK rises at this edge.
  - fall = (cnt[3:0]==15): SCLK falls at this edge.
- Reset values (rst_n low at an edge): cnt=0, MCLK=SCLK=LRCLK=0, SDin=0, RSTn=0, valid=0, lft_in=rht_in=0. All shift and hold registers clear.
- RSTn: stays 0 until the first edge where cnt==0x3FF, then 1 from the next cycle until the next reset.
- A "live" flag sets on that same edge. Frames are processed only while live=1.
- Receive (I2S format, MSB in slot 1):
  - On each rise edge with slot in 1..DATA_W, SDout shifts into the current channel's shift register, MSB first.
  - Slot 0 and slots above DATA_W are ignored.
- Frame boundary (edge where cnt==0x3FF and live==1):
  - lft_in <= left shift register and rht_in <= right shift register.
  - Transmit holds capture lft_out/rht_out.
  - valid=1 during the following cycle (cnt==0) only.
- First valid pulse is at cnt==0 of the second frame after reset release, i.e. 2048 clks after rst_n goes high. The partial frame before live is discarded.
- Transmit:
  - On each fall edge, SDin is driven with the bit for slot s+1 (mod 32) of the channel selected by the next LRCLK value.
  - Value is bit (DATA_W - s') of the held sample for s' in 1..DATA_W, else 0. Slot 0 is always 0.
  - Before live, SDin=0.
- SDin changes only on fall edges, so it is stable for 8 clks around each SCLK rise.
- Receive/transmit latency:
  - ADC sample appears on lft_in/rht_in at the end of the frame in which it was received.
  - lft_out/rht_out presented at valid are transmitted in the next frame.
- Data arithmetic: none; samples pass through bit-exact (two's-complement untouched).
- Reset mid-operation: the next cycle shows full reset values. RSTn drops to 0, partially received and transmitted frames are discarded, and the sequence restarts from cnt=0.
- lft_out/rht_out changing mid-frame has no effect; only the value at the frame boundary is used.

Test Plan:
- Reset hold 5 clks then release:
  - All outputs 0 during reset.
  - MCLK period 4 clks, SCLK period 16, LRCLK period 1024, at 50% duty.
  - RSTn rises at clk 1024 after release.
- Valid cadence:
  - First valid at clk 2048 after release, then every 1024 clks.
  - Each pulse exactly 1 clk wide, coincident with cnt==0 / LRCLK falling.
- Receive:
  - Bench drives SDout I2S with left=16'hA5C3, right=16'h1234, each bit changing on SCLK fall.
  - At the next valid: lft_in=16'hA5C3, rht_in=16'h1234.
- Transmit:
  - lft_out=16'h8001, rht_out=16'h7FFE held through a frame boundary.
  - Next frame SDin left slots 1..16 = 1000_0000_0000_0001, right slots 1..16 = 0111_1111_1111_1110, and slot 0 plus slots 17..31 = 0.
- Loopback through the CS4272 model:
  - Ramp samples 0,1,2,... on lft_out/rht_out.
  - aout_lft/aout_rht reproduce the ramp, with lft_in tracking after the model's fixed latency.
  - No valid or RSTn glitches.
- Mid-frame reset:
  - Assert rst_n low at cnt==0x150 for 1 clk.
  - Next cycle all outputs are at reset values; RSTn is low again for 1024 clks; no valid pulse until 2048 clks after release.
